// File: rtl/uart_frame_decoder.sv
// Framing engine on the FIFO side of a UART: hunts SYNC, checks LEN, streams the payload,
// verifies the checksum and answers each frame with an ACK/NAK byte.
module uart_frame_decoder #(
    parameter int                   DATA_BITS     = 8,
    parameter logic [DATA_BITS-1:0] SYNC_BYTE     = 8'hA5,
    parameter int                   MAX_LEN       = 16,
    parameter logic [DATA_BITS-1:0] ACK_BYTE      = 8'h06,
    parameter logic [DATA_BITS-1:0] NAK_BYTE      = 8'h15,
    parameter int                   TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_empty,
    input  logic [DATA_BITS-1:0]     rd_data,
    output logic                     rd_uart,
    input  logic                     tx_full,
    output logic                     wr_uart,
    output logic [DATA_BITS-1:0]     wr_data,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    output logic [DATA_BITS-1:0]     m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_sof,
    output logic                     m_eof,
    output logic                     frame_ok,
    output logic                     frame_err,
    output logic [1:0]               err_code
);

    localparam logic [DATA_BITS-1:0] MAX_LEN_B = DATA_BITS'(MAX_LEN);
    localparam logic [DATA_BITS-1:0] ONE_B     = DATA_BITS'(1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_RESP} state_t;

    state_t                   state, state_n;
    logic [DATA_BITS-1:0]     acc;
    logic [DATA_BITS-1:0]     cnt;
    logic                     first;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic [1:0]               err_code_n;
    logic [DATA_BITS-1:0]     chk_sum;
    logic [TIMEOUT_WIDTH:0]   tmo_seen;
    logic                     tmo_hit;

    assign chk_sum  = acc + rd_data;
    // tmo_seen counts the current empty cycle too, so the error lands exactly
    // timeout_cycles cycles after the last pop.
    assign tmo_seen = {1'b0, tmo_cnt} + (TIMEOUT_WIDTH+1)'(1);
    assign tmo_hit  = rx_empty && (timeout_cycles != '0) && (tmo_seen == {1'b0, timeout_cycles});

    always_comb begin
        state_n    = state;
        err_code_n = err_code;
        rd_uart    = 1'b0;
        wr_uart    = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_sof      = 1'b0;
        m_eof      = 1'b0;
        frame_ok   = 1'b0;
        frame_err  = 1'b0;
        case (state)
            S_IDLE: begin
                rd_uart = !rx_empty;
                if (!rx_empty && rd_data == SYNC_BYTE) state_n = S_LEN;
            end
            S_LEN: begin
                rd_uart = !rx_empty;
                if (!rx_empty) begin
                    if (rd_data == '0 || rd_data > MAX_LEN_B) begin
                        frame_err  = 1'b1;
                        err_code_n = 2'b10;
                        state_n    = S_RESP;
                    end else begin
                        state_n = S_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    frame_err  = 1'b1;
                    err_code_n = 2'b11;
                    state_n    = S_RESP;
                end
            end
            S_PAYLOAD: begin
                m_valid = !rx_empty;
                m_data  = rd_data;
                m_sof   = !rx_empty && first;
                m_eof   = !rx_empty && (cnt == ONE_B);
                rd_uart = !rx_empty && m_ready;
                if (rd_uart && cnt == ONE_B) begin
                    state_n = S_CHK;
                end else if (tmo_hit) begin
                    frame_err  = 1'b1;
                    err_code_n = 2'b11;
                    state_n    = S_RESP;
                end
            end
            S_CHK: begin
                rd_uart = !rx_empty;
                if (!rx_empty) begin
                    frame_ok   = (chk_sum == '0);
                    frame_err  = (chk_sum != '0);
                    err_code_n = (chk_sum == '0) ? 2'b00 : 2'b01;
                    state_n    = S_RESP;
                end else if (tmo_hit) begin
                    frame_err  = 1'b1;
                    err_code_n = 2'b11;
                    state_n    = S_RESP;
                end
            end
            S_RESP: begin
                wr_uart = !tx_full;
                if (!tx_full) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // Outputs read as zero for the whole time reset is held.
        if (reset) begin
            rd_uart   = 1'b0;
            wr_uart   = 1'b0;
            m_valid   = 1'b0;
            m_data    = '0;
            m_sof     = 1'b0;
            m_eof     = 1'b0;
            frame_ok  = 1'b0;
            frame_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            acc      <= '0;
            cnt      <= '0;
            first    <= 1'b0;
            tmo_cnt  <= '0;
            wr_data  <= '0;
            err_code <= 2'b00;
        end else begin
            state    <= state_n;
            err_code <= err_code_n;
            if (frame_ok)       wr_data <= ACK_BYTE;
            else if (frame_err) wr_data <= NAK_BYTE;
            if (state == S_LEN && rd_uart && state_n == S_PAYLOAD) begin
                acc   <= rd_data;
                cnt   <= rd_data;
                first <= 1'b1;
            end else if (state == S_PAYLOAD && rd_uart) begin
                acc   <= acc + rd_data;
                cnt   <= cnt - ONE_B;
                first <= 1'b0;
            end
            // Only starved cycles age the timeout; backpressure with data present holds it.
            if ((state == S_LEN || state == S_PAYLOAD || state == S_CHK) && !rd_uart) begin
                if (rx_empty) tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: an rx FIFO model feeds byte vectors, monitors log
// payload, responses and result pulses, and expected values are hand-computed per vector.
module tb_uart_frame_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_empty;
    logic [7:0]  rd_data;
    logic        rd_uart;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  wr_data;
    logic [15:0] timeout_cycles;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_eof;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    uart_frame_decoder dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .rd_data(rd_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .wr_uart(wr_uart), .wr_data(wr_data), .timeout_cycles(timeout_cycles),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eof(m_eof),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
    );

    // rx FIFO model: first-word fall-through, popped on the clock edge.
    logic [7:0] rx_mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign rx_empty = (rd_ptr == wr_ptr);
    assign rd_data  = rx_mem[rd_ptr];
    always @(posedge clk) if (rd_uart && !rx_empty) rd_ptr <= rd_ptr + 8'd1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    int         viol = 0;
    int         wr_any = 0;
    int         pay_n = 0, tx_n = 0, ok_n = 0, err_n = 0;
    int         ok_c = 0, err_c = 0, tx_c = 0;
    logic [7:0] pay_d [0:63];
    logic       pay_s [0:63];
    logic       pay_e [0:63];
    int         pay_c [0:63];
    logic [7:0] tx_d  [0:63];

    always @(negedge clk) begin
        if (rd_uart && rx_empty) viol++;
        if (frame_ok && frame_err) viol++;
        if (wr_uart) wr_any++;
        if (!reset) begin
            if (m_valid && m_ready) begin
                pay_d[pay_n % 64] = m_data;
                pay_s[pay_n % 64] = m_sof;
                pay_e[pay_n % 64] = m_eof;
                pay_c[pay_n % 64] = cyc;
                pay_n++;
            end
            if (wr_uart && !tx_full) begin
                tx_d[tx_n % 64] = wr_data;
                tx_c = cyc;
                tx_n++;
            end
            if (frame_ok)  begin ok_n++;  ok_c = cyc;  end
            if (frame_err) begin err_n++; err_c = cyc; end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        logic [7:0] b [6];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4; b[5] = b5;
        for (int i = 0; i < n; i++) begin
            rx_mem[wr_ptr] = b[i];
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic wait_tx(input int target, input int budget, input string tag, input bit bp);
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        while (tx_n < target && k < budget) begin
            tick();
            if (bp) m_ready = pat[k % 4];
            k++;
        end
        m_ready = 1'b1;
        check({tag, "_resp_seen"}, 32'(tx_n >= target), 1);
    endtask

    // Checks a logged payload beat as {sof, eof, data}.
    task automatic chk_pay(input string tag, input int idx, input logic [31:0] exp);
        check(tag, 32'({pay_s[idx % 64], pay_e[idx % 64], pay_d[idx % 64]}), exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    int b_tx, b_pay, b_ok, b_err, k;
    logic [7:0] rp;
    int wa;

    initial begin
        m_ready = 1'b1;
        tx_full = 1'b0;
        timeout_cycles = 16'd0;
        repeat (2) tick();
        push(1, 8'h00, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_rd_uart", 32'(rd_uart), 0);
        check("rst_outs", 32'({wr_uart, m_valid, m_sof, m_eof, frame_ok, frame_err}), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        tick();
        reset = 1'b0;

        // Good frame: 03+10+20+30 = 63, 63+9D = 100.
        b_tx = tx_n; b_pay = pay_n; b_ok = ok_n; b_err = err_n;
        push(6, 8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9D);
        wait_tx(b_tx + 1, 60, "good", 1'b0);
        repeat (3) tick();
        check("good_pay_n", pay_n - b_pay, 3);
        chk_pay("good_beat0", b_pay, 'h210);
        chk_pay("good_beat1", b_pay + 1, 'h020);
        chk_pay("good_beat2", b_pay + 2, 'h130);
        check("good_ok", ok_n - b_ok, 1);
        check("good_err", err_n - b_err, 0);
        check("good_code", 32'(err_code), 0);
        check("good_tx_n", tx_n - b_tx, 1);
        check("good_tx_byte", 32'(tx_d[b_tx % 64]), 'h06);
        check("good_latency", tx_c - ok_c, 1);

        // Bad checksum, then a good one-byte frame: 01+42 = 43, 43+BD = 100.
        b_tx = tx_n; b_pay = pay_n; b_ok = ok_n; b_err = err_n;
        push(6, 8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9C);
        wait_tx(b_tx + 1, 60, "badchk", 1'b0);
        check("badchk_pay_n", pay_n - b_pay, 3);
        check("badchk_err", err_n - b_err, 1);
        check("badchk_ok", ok_n - b_ok, 0);
        check("badchk_code", 32'(err_code), 1);
        check("badchk_tx_byte", 32'(tx_d[b_tx % 64]), 'h15);
        b_tx = tx_n; b_pay = pay_n;
        push(4, 8'hA5, 8'h01, 8'h42, 8'hBD, 0, 0);
        wait_tx(b_tx + 1, 60, "recover", 1'b0);
        chk_pay("recover_beat", b_pay, 'h342);
        check("recover_code", 32'(err_code), 0);
        check("recover_tx_byte", 32'(tx_d[b_tx % 64]), 'h06);

        // Length errors, with leading garbage dropped silently.
        b_tx = tx_n; b_err = err_n;
        push(4, 8'h00, 8'hFF, 8'hA5, 8'h00, 0, 0);
        wait_tx(b_tx + 1, 60, "len0", 1'b0);
        repeat (5) tick();
        check("len0_tx_n", tx_n - b_tx, 1);
        check("len0_code", 32'(err_code), 2);
        check("len0_tx_byte", 32'(tx_d[b_tx % 64]), 'h15);
        b_tx = tx_n;
        push(2, 8'hA5, 8'h11, 0, 0, 0, 0);
        wait_tx(b_tx + 1, 60, "len17", 1'b0);
        check("len17_code", 32'(err_code), 2);
        check("len17_tx_byte", 32'(tx_d[b_tx % 64]), 'h15);
        check("len_err_n", err_n - b_err, 2);

        // Backpressure 1-0-0-1 with a short timeout: 04+01+02+03+04 = 0E, 0E+F2 = 100.
        timeout_cycles = 16'd4;
        b_tx = tx_n; b_pay = pay_n; b_err = err_n;
        push(6, 8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04);
        push(1, 8'hF2, 0, 0, 0, 0, 0);
        wait_tx(b_tx + 1, 80, "bp", 1'b1);
        check("bp_pay_n", pay_n - b_pay, 4);
        check("bp_data", 32'({pay_d[b_pay % 64], pay_d[(b_pay + 1) % 64],
                              pay_d[(b_pay + 2) % 64], pay_d[(b_pay + 3) % 64]}), 'h01020304);
        check("bp_err", err_n - b_err, 0);
        check("bp_tx_byte", 32'(tx_d[b_tx % 64]), 'h06);

        // Timeout after the first payload byte.
        timeout_cycles = 16'd10;
        b_tx = tx_n; b_pay = pay_n; b_err = err_n;
        push(3, 8'hA5, 8'h02, 8'h11, 0, 0, 0);
        wait_tx(b_tx + 1, 60, "tmo", 1'b0);
        check("tmo_err", err_n - b_err, 1);
        check("tmo_delay", err_c - pay_c[b_pay % 64], 10);
        check("tmo_code", 32'(err_code), 3);
        check("tmo_tx_byte", 32'(tx_d[b_tx % 64]), 'h15);

        // Timeout disabled: a long stall produces nothing, then the frame completes (02+11+22+CB = 100).
        timeout_cycles = 16'd0;
        b_tx = tx_n; b_err = err_n;
        push(3, 8'hA5, 8'h02, 8'h11, 0, 0, 0);
        repeat (1000) tick();
        check("notmo_err", err_n - b_err, 0);
        check("notmo_tx_n", tx_n - b_tx, 0);
        push(2, 8'h22, 8'hCB, 0, 0, 0, 0);
        wait_tx(b_tx + 1, 60, "notmo", 1'b0);
        check("notmo_tx_byte", 32'(tx_d[b_tx % 64]), 'h06);

        // tx FIFO full during the response.
        tx_full = 1'b1;
        b_tx = tx_n; b_ok = ok_n;
        push(5, 8'hA5, 8'h01, 8'h42, 8'hBD, 8'h77, 0);
        k = 0;
        while (ok_n == b_ok && k < 40) begin tick(); k++; end
        check("full_ok_seen", 32'(ok_n > b_ok), 1);
        rp = rd_ptr;
        wa = wr_any;
        repeat (20) tick();
        check("full_no_wr", wr_any - wa, 0);
        check("full_no_pop", 32'(rd_ptr), 32'(rp));
        tx_full = 1'b0;
        wait_tx(b_tx + 1, 10, "full", 1'b0);
        repeat (5) tick();
        check("full_tx_n", tx_n - b_tx, 1);
        check("full_tx_byte", 32'(tx_d[b_tx % 64]), 'h06);
        check("full_drained", 32'(rx_empty), 1);

        // Reset in the middle of a payload.
        b_tx = tx_n; b_pay = pay_n;
        push(4, 8'hA5, 8'h05, 8'h01, 8'h02, 0, 0);
        k = 0;
        while (pay_n - b_pay < 2 && k < 40) begin tick(); k++; end
        check("midrst_pay_n", pay_n - b_pay, 2);
        push(1, 8'h03, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_outs", 32'({rd_uart, wr_uart, m_valid, m_sof, m_eof, frame_ok, frame_err}), 0);
        tick();
        check("midrst_wr_data", 32'(wr_data), 0);
        check("midrst_code", 32'(err_code), 0);
        reset = 1'b0;
        b_pay = pay_n;
        push(4, 8'hA5, 8'h01, 8'h42, 8'hBD, 0, 0);
        wait_tx(b_tx + 1, 60, "midrst", 1'b0);
        check("midrst_tx_n", tx_n - b_tx, 1);
        check("midrst_tx_byte", 32'(tx_d[b_tx % 64]), 'h06);
        chk_pay("midrst_beat", b_pay, 'h342);

        check("protocol_violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
